// File: rtl/sync_fifo_prefetch_flex.sv
// Single-clock first-word-fall-through FIFO: inferred RAM feeding a registered head word,
// with occupancy level, almost-full/empty thresholds, sync flush and sticky ovf/unf flags.
module sync_fifo_prefetch_flex #(
  parameter int DATA_W    = 32,
  parameter int DEPTH_W   = 8,
  parameter int AF_THRESH = (1 << DEPTH_W) - 4,
  parameter int AE_THRESH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_vld,
  input  logic               rd_en,
  output logic               rd_vld,
  output logic [DATA_W-1:0]  rd_data,
  output logic [DEPTH_W:0]   level,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               ovf,
  output logic               unf
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] AF_L = (DEPTH_W+1)'(AF_THRESH);
  localparam logic [DEPTH_W:0] AE_L = (DEPTH_W+1)'(AE_THRESH);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic               wr_acc, pop, load, ram_ne;
  logic [DEPTH_W:0]   level_nxt;

  // level never exceeds DEPTH, so its MSB alone marks full
  assign wr_vld = ~level[DEPTH_W];
  assign wr_acc = wr_en & wr_vld & ~flush;
  assign pop    = rd_en & rd_vld & ~flush;
  // RAM occupancy is level minus the head-register word
  assign ram_ne = (level != {{DEPTH_W{1'b0}}, rd_vld});
  assign load   = ram_ne & (~rd_vld | pop) & ~flush;
  assign level_nxt = level + {{DEPTH_W{1'b0}}, wr_acc} - {{DEPTH_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level        <= '0;
      rd_vld       <= 1'b0;
      rd_data      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      ovf          <= 1'b0;
      unf          <= 1'b0;
    end else if (flush) begin
      level        <= '0;
      rd_vld       <= 1'b0;
      rd_data      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      almost_full  <= (AF_L == '0);
      almost_empty <= 1'b1;
      ovf          <= 1'b0;
      unf          <= 1'b0;
    end else begin
      level        <= level_nxt;
      almost_full  <= (level_nxt >= AF_L);
      almost_empty <= (level_nxt <= AE_L);
      ovf          <= ovf | (wr_en & ~wr_vld);
      unf          <= unf | (rd_en & ~rd_vld);
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      // head register refills from RAM whenever it is empty or being popped
      if (load) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
        rd_vld  <= 1'b1;
      end else if (pop) begin
        rd_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_prefetch_flex.sv
// Randomised scoreboard bench for sync_fifo_prefetch_flex: a queue-based model tracks
// contents and visibility times; a negedge monitor compares every output each cycle.
module tb_sync_fifo_prefetch_flex;
  localparam int DW = 32;
  localparam int DEPTH_W = 8;
  localparam int DEPTH = 1 << DEPTH_W;
  localparam int AF = DEPTH - 4;
  localparam int AE = 4;

  logic clk = 0, rst = 1, flush = 0, wr_en = 0, rd_en = 0;
  logic [DW-1:0] wr_data = '0;
  logic wr_vld, rd_vld, almost_full, almost_empty, ovf, unf;
  logic [DW-1:0] rd_data;
  logic [DEPTH_W:0] level;

  sync_fifo_prefetch_flex #(.DATA_W(DW), .DEPTH_W(DEPTH_W), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .wr_vld(wr_vld),
    .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data), .level(level),
    .almost_full(almost_full), .almost_empty(almost_empty), .ovf(ovf), .unf(unf));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted word remembers the edge it was accepted on;
  // it becomes visible at the head one edge later.
  typedef struct { logic [DW-1:0] d; int t; } ent_t;
  ent_t q[$];
  int cyc = 0;
  bit m_ovf = 0, m_unf = 0, m_vis, m_full;
  logic [DW-1:0] last = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); cyc = 0; m_ovf = 0; m_unf = 0; last = '0;
    end else begin
      if (flush) begin
        q.delete(); m_ovf = 0; m_unf = 0; last = '0;
      end else begin
        m_vis  = (q.size() > 0) && (q[0].t + 1 < cyc);
        m_full = (q.size() == DEPTH);
        if (wr_en && m_full) m_ovf = 1;
        if (rd_en && !m_vis) m_unf = 1;
        if (rd_en && m_vis) void'(q.pop_front());
        if (wr_en && !m_full) q.push_back('{wr_data, cyc});
      end
      cyc++;
    end
  end

  // Monitor: compares every output against the model between edges
  always @(negedge clk) begin
    if (!rst) begin
      automatic bit vis = (q.size() > 0) && (q[0].t + 1 < cyc);
      automatic logic [DW-1:0] exp_d = vis ? q[0].d : last;
      chk("level", 64'(level), 64'(q.size()));
      chk("rd_vld", 64'(rd_vld), 64'(vis));
      chk("rd_data", 64'(rd_data), 64'(exp_d));
      chk("wr_vld", 64'(wr_vld), 64'(q.size() < DEPTH));
      chk("almost_full", 64'(almost_full), 64'(q.size() >= AF));
      chk("almost_empty", 64'(almost_empty), 64'(q.size() <= AE));
      chk("ovf", 64'(ovf), 64'(m_ovf));
      chk("unf", 64'(unf), 64'(m_unf));
      if (vis) last = q[0].d;
    end
  end

  task automatic step(input bit w, input bit r, input bit f);
    @(negedge clk);
    #1;
    wr_en = w; rd_en = r; flush = f; wr_data = $urandom;
  endtask

  task automatic check_reset();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_rd_vld", 64'(rd_vld), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_wr_vld", 64'(wr_vld), 64'd1);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_ae", 64'(almost_empty), 64'd1);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_unf", 64'(unf), 64'd0);
  endtask

  initial begin
    #12 check_reset();
    @(negedge clk); rst = 0;
    // first word fall-through latency
    @(negedge clk); #1; wr_en = 1; wr_data = 32'hA5A5_0001;
    @(negedge clk); #1; wr_en = 0;
    @(negedge clk);
    chk("fwft_data", 64'(rd_data), 64'hA5A5_0001);
    chk("fwft_vld", 64'(rd_vld), 64'd1);
    repeat (3) step(0, 0, 0);
    // fill to full, then overflow attempts
    step(0, 0, 1);
    repeat (DEPTH + 4) step(1, 0, 0);
    step(0, 0, 0);
    chk("full_ovf", 64'(ovf), 64'd1);
    chk("full_level", 64'(level), 64'(DEPTH));
    // half full then sustained simultaneous read/write
    step(0, 0, 1);
    repeat (DEPTH / 2) step(1, 0, 0);
    repeat (1000) step(1, 1, 0);
    step(0, 0, 0);
    // underflow on empty, then flush clears it
    step(0, 0, 1);
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);
    chk("unf_set", 64'(unf), 64'd1);
    step(0, 0, 1);
    step(0, 0, 0);
    // flush wins over same-cycle wr_en/rd_en
    repeat (10) step(1, 0, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    chk("flush_level", 64'(level), 64'd0);
    // pointer wrap
    for (int k = 0; k < 3; k++) begin
      repeat (200) step(1, 0, 0);
      repeat (200) step(0, 1, 0);
    end
    // random traffic with occasional flush
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom_range(0, 199) == 0);
    // async reset mid-burst
    repeat (50) step(1, $urandom_range(0, 1) == 1, 0);
    #2 rst = 1;
    #1 check_reset();
    @(negedge clk); wr_en = 0; rd_en = 0; flush = 0; rst = 0;
    @(negedge clk); #1; wr_en = 1; wr_data = 32'h1234_5678;
    @(negedge clk); #1; wr_en = 0;
    @(negedge clk);
    chk("post_rst_data", 64'(rd_data), 64'h1234_5678);
    repeat (3) step(0, 1, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
